mod_sum_select_stage: RTL and testbench
=======================================

// Module: mod_sum_select_stage
// PURPOSE
// - Final stage of the (A+B) mod M adder. It sits directly after the parallel-prefix network.
// - Forms both candidate sums: S0 = A+B and S1 = A+B+K, where K = 2^n - M.
// - Selects the modulo-reduced result and registers it behind a valid/ready handshake.
// - A 2-entry skid buffer decouples the prefix network from the downstream consumer.
// PARAMETERS
// - N     7  operand/result width in bits; the modulus is M = 2^N - K.
// - CNT_W 16 width of the correction counter (used only with MOD_CORR_CNT_EN).
// PORTS
// - clk        in  1      rising-edge clock; the only clock.
// - rst        in  1      synchronous, active-high reset.
// - in_valid   in  1      upstream prefix outputs are valid this cycle.
// - in_ready   out 1      stage can accept; a transfer occurs when in_valid & in_ready.
// - h_v        in  N      half-sum a^b from the hashed cells.
// - hp_v       in  N      half-sum of the envelope cells (carry-save A+B+K).
// - gc_v       in  N      prefix group-generate for A+B; bit i is the carry out of bit i.
// - gpc_v      in  N      prefix group-generate for the A+B+K path.
// - bp_msb     in  1      hashed-cell bp[N-1], the carry-save carry dropped off the top.
// - out_valid  out 1      result is valid.
// - out_ready  in  1      downstream accepts; the result is consumed when out_valid & out_ready.
// - sum_o      out N      (A+B) mod M.
// - corr_o     out 1      1 if S1 was selected (A+B >= M).
// - corr_cnt_o out CNT_W  number of corrected results (only with MOD_CORR_CNT_EN).
// BEHAVIOUR
// - Combinational front end:
//   - s0[0] = h_v[0];  s0[i] = h_v[i] ^ gc_v[i-1].
//   - s1[0] = hp_v[0]; s1[i] = hp_v[i] ^ gpc_v[i-1].
//   - sel = bp_msb | gpc_v[N-1], i.e. the carry out of A+B+K. This means A+B >= M.
//   - res = sel ? s1 : s0. All arithmetic is N-bit, and the carries out of s0/s1 are discarded.
// - Operands satisfy A, B < M. Results for operands >= M are undefined but must not corrupt the handshake state.
// - Buffer: 2-entry FIFO of {res, sel}. Head entry drives sum_o/corr_o.
//   - in_ready = (count < 2). It depends on registered state only, with no combinational path from out_ready.
//   - out_valid = (count != 0).
// - Latency: 1 cycle from an accepted input to out_valid when the buffer is empty.
// - Throughput: 1 result per cycle while out_ready = 1.
// - FSM on count, with states EMPTY(0), ONE(1), FULL(2):
//   - EMPTY: push -> ONE.
//   - ONE: push without pop -> FULL; pop without push -> EMPTY; push and pop together -> ONE, head replaced by new data.
//   - FULL: in_ready = 0, so no push; pop -> ONE, second entry moves to head.
// - Order is strictly FIFO. Data must hold stable while out_valid & !out_ready.
// - Reset, including mid-transfer:
//   - count = 0, out_valid = 0, in_ready = 1 in the first cycle after rst.
//   - sum_o = 0, corr_o = 0, corr_cnt_o = 0.
//   - Buffered entries are dropped.
// - An in_valid asserted during rst is ignored.
// CONFIGURATION
// - MOD_CORR_CNT_EN defined:
//   - corr_cnt_o increments on each output transfer with corr_o = 1.
//   - It saturates at 2^CNT_W - 1 and is cleared by rst.
// - MOD_CORR_CNT_EN undefined:
//   - corr_cnt_o is tied to 0 and the counter logic is removed.
//   - The port stays so the port list is stable.
// STRUCTURE
// - Package mod_adder_pkg holds:
//   - default N and the localparam K_DEFAULT = 28 (M = 100 for N = 7);
//   - typedef logic [N-1:0] word_t;
//   - typedef struct packed {word_t sum; logic corr;} mod_res_t;
//   - typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t.
// - One sub-module, mod_sum_select: the purely combinational s0/s1/sel/res logic. The top level holds the buffer and the counter.
// TESTING
// - The bench derives the stage inputs from (A, B, K) with a behavioural model of the hashed, envelope and prefix cells.
// - Directed cases use N = 7, K = 28 (M = 100):
//   1. A=60, B=50, out_ready=1 -> sum_o=10, corr_o=1, out_valid exactly 1 cycle after acceptance.
//   2. A=30, B=40 -> sum_o=70, corr_o=0. Also A=50, B=50 -> sum_o=0, corr_o=1 (boundary A+B = M).
//   3. A=99, B=99 -> sum_o=98, corr_o=1, with bp_msb=1 exercising the carry-save carry path.
//   4. Hold out_ready=0 and offer 3 inputs (10+1, 20+2, 30+3):
//      - in_ready drops after 2 accepts and the third waits;
//      - on release, outputs are 11, 22, 33 in order with no loss or duplication.
//   5. Streaming 1000 random pairs with random out_ready and simultaneous push/pop -> all results equal (A+B)%100, in order.
//   6. Assert rst while FULL -> next cycle out_valid=0, in_ready=1, sum_o=0. With MOD_CORR_CNT_EN, corr_cnt_o=0. A new input then completes normally.
//   7. With MOD_CORR_CNT_EN and CNT_W=2: 5 corrected results -> corr_cnt_o saturates at 3.

Source files
------------

// File: rtl/mod_sum_select_stage_pkg.sv
// Shared types for the (A+B) mod M adder: default widths, result payload and skid-buffer states.
package mod_adder_pkg;

  localparam int unsigned N_DEFAULT     = 7;
  localparam int unsigned K_DEFAULT     = 28;
  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef logic [N_DEFAULT-1:0] word_t;

  typedef struct packed {
    word_t sum;
    logic  corr;
  } mod_res_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/mod_sum_select_stage_select.sv
// Combinational sum formation for both candidates (A+B and A+B+K) and the modulo select.
module mod_sum_select #(
  parameter int unsigned N = 7
) (
  input  logic [N-1:0] h_v,
  input  logic [N-1:0] hp_v,
  input  logic [N-1:0] gc_v,
  input  logic [N-1:0] gpc_v,
  input  logic         bp_msb,
  output logic [N-1:0] res_c,
  output logic         sel_c
);

  logic [N-1:0] s0_c;
  logic [N-1:0] s1_c;
  logic         unused_carry;

  // Carry out of A+B is meaningless once the A+B+K carry decides the range.
  assign unused_carry = gc_v[N-1];

  always_comb begin
    s0_c  = h_v  ^ {gc_v[N-2:0],  1'b0};
    s1_c  = hp_v ^ {gpc_v[N-2:0], 1'b0};
    sel_c = bp_msb | gpc_v[N-1];
    res_c = sel_c ? s1_c : s0_c;
  end

endmodule

// File: rtl/mod_sum_select_stage.sv
// Final stage of the modular adder: sum select plus a 2-entry registered skid buffer.
// Optional correction counter enabled by defining MOD_CORR_CNT_EN.
module mod_sum_select_stage
  import mod_adder_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     h_v,
  input  logic [N-1:0]     hp_v,
  input  logic [N-1:0]     gc_v,
  input  logic [N-1:0]     gpc_v,
  input  logic             bp_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     sum_o,
  output logic             corr_o,
  output logic [CNT_W-1:0] corr_cnt_o
);

  buf_state_t   state;
  logic [N-1:0] res_c;
  logic         sel_c;
  logic [N-1:0] tail_sum;
  logic         tail_corr;
  logic         push_c;
  logic         pop_c;

  mod_sum_select #(.N(N)) u_select (
    .h_v    (h_v),
    .hp_v   (hp_v),
    .gc_v   (gc_v),
    .gpc_v  (gpc_v),
    .bp_msb (bp_msb),
    .res_c  (res_c),
    .sel_c  (sel_c)
  );

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  // Head entry lives directly in sum_o/corr_o; the tail only fills while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum_o     <= '0;
      corr_o    <= 1'b0;
      tail_sum  <= '0;
      tail_corr <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push_c) begin
            sum_o     <= res_c;
            corr_o    <= sel_c;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push_c && pop_c) begin
            sum_o  <= res_c;
            corr_o <= sel_c;
          end else if (push_c) begin
            tail_sum  <= res_c;
            tail_corr <= sel_c;
            in_ready  <= 1'b0;
            state     <= FULL;
          end else if (pop_c) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (pop_c) begin
            sum_o    <= tail_sum;
            corr_o   <= tail_corr;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOD_CORR_CNT_EN
  // Saturating count of corrected results leaving the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_o <= '0;
    end else if (pop_c && corr_o && (corr_cnt_o != {CNT_W{1'b1}})) begin
      corr_cnt_o <= corr_cnt_o + CNT_W'(1);
    end
  end
`else
  assign corr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mod_sum_select_stage.sv
// Directed and streaming bench for mod_sum_select_stage with N=7, K=28 (M=100).
module tb_mod_sum_select_stage;
  import mod_adder_pkg::*;

  localparam int unsigned N = 7;
  localparam logic [6:0]  K = 7'd28;
`ifdef MOD_CORR_CNT_EN
  localparam int unsigned CNT_W  = 2;
  localparam bit          CNT_EN = 1'b1;
`else
  localparam int unsigned CNT_W  = 16;
  localparam bit          CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     h_v, hp_v, gc_v, gpc_v;
  logic             bp_msb;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     sum_o;
  logic             corr_o;
  logic [CNT_W-1:0] corr_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_sum_select_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .h_v        (h_v),
    .hp_v       (hp_v),
    .gc_v       (gc_v),
    .gpc_v      (gpc_v),
    .bp_msb     (bp_msb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum_o      (sum_o),
    .corr_o     (corr_o),
    .corr_cnt_o (corr_cnt_o)
  );

  // Behavioural hashed/envelope/prefix cells: carries recovered from integer sums.
  task automatic apply(input logic [6:0] a, input logic [6:0] b);
    logic [7:0] cin_ab;
    logic [6:0] ps, pc, pcs;
    logic [7:0] cin_k;
    cin_ab = ({1'b0, a} + {1'b0, b}) ^ {1'b0, a} ^ {1'b0, b};
    h_v    = a ^ b;
    gc_v   = cin_ab[7:1];
    ps     = a ^ b ^ K;
    pc     = (a & b) | (a & K) | (b & K);
    pcs    = {pc[5:0], 1'b0};
    bp_msb = pc[6];
    hp_v   = ps ^ pcs;
    cin_k  = ({1'b0, ps} + {1'b0, pcs}) ^ {1'b0, ps} ^ {1'b0, pcs};
    gpc_v  = cin_k[7:1];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the buffer empty and out_ready=1.
  task automatic send_one(input string tag, input logic [6:0] a, input logic [6:0] b,
                          input int es, input int ec);
    apply(a, b);
    in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"},   32'(sum_o),     32'(es));
    chk({tag, "_corr"},  32'(corr_o),    32'(ec));
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    mod_res_t   q[$];
    mod_res_t   e;
    logic [6:0] ca, cb;
    bit         hold;
    int         acc, cyc, s;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    apply(7'd0, 7'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid),  32'd0);
    chk("rst_ready", 32'(in_ready),   32'd1);
    chk("rst_sum",   32'(sum_o),      32'd0);
    chk("rst_corr",  32'(corr_o),     32'd0);
    chk("rst_cnt",   32'(corr_cnt_o), 32'd0);
    rst = 1'b0;

    send_one("c1_60_50", 7'd60, 7'd50, 10, 1);
    send_one("c2_30_40", 7'd30, 7'd40, 70, 0);
    send_one("c2_50_50", 7'd50, 7'd50, 0,  1);
    send_one("c3_99_99", 7'd99, 7'd99, 98, 1);

    // Stall: two entries fill the buffer, the third must wait.
    out_ready = 1'b0;
    apply(7'd10, 7'd1); in_valid = 1'b1;
    @(negedge clk);
    chk("c4_ready1", 32'(in_ready), 32'd1);
    apply(7'd20, 7'd2);
    @(negedge clk);
    chk("c4_full_ready", 32'(in_ready),  32'd0);
    chk("c4_full_valid", 32'(out_valid), 32'd1);
    chk("c4_head11",     32'(sum_o),     32'd11);
    apply(7'd30, 7'd3);
    @(negedge clk);
    chk("c4_blocked",  32'(in_ready), 32'd0);
    chk("c4_stable11", 32'(sum_o),    32'd11);
    out_ready = 1'b1;
    @(negedge clk);
    chk("c4_out22",  32'(sum_o),    32'd22);
    chk("c4_ready2", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("c4_out33",   32'(sum_o),     32'd33);
    chk("c4_valid33", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("c4_empty", 32'(out_valid), 32'd0);

    // Random stream with random backpressure against an in-order scoreboard.
    acc = 0; cyc = 0; hold = 1'b0; ca = '0; cb = '0;
    while (acc < 1000 && cyc < 20000) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        ca = 7'($urandom_range(0, 99));
        cb = 7'($urandom_range(0, 99));
        apply(ca, cb);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $error("FAIL stream_extra observed=%0d expected=none", sum_o);
        end else begin
          e = q.pop_front();
          chk("stream_sum",  32'(sum_o),  32'(e.sum));
          chk("stream_corr", 32'(corr_o), 32'(e.corr));
        end
      end
      if (in_valid && in_ready) begin
        s = int'(ca) + int'(cb);
        e.sum  = 7'(s % 100);
        e.corr = (s >= 100);
        q.push_back(e);
        acc++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream_accepted", 32'(acc), 32'd1000);
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        chk("drain_sum", 32'(sum_o), 32'(e.sum));
      end
      @(negedge clk);
      cyc++;
    end
    chk("drain_left",  32'(q.size()),  32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Reset while full, with in_valid held high during reset.
    out_ready = 1'b0;
    apply(7'd10, 7'd1); in_valid = 1'b1;
    @(negedge clk);
    apply(7'd20, 7'd2);
    @(negedge clk);
    chk("c6_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    apply(7'd99, 7'd99);
    @(negedge clk);
    chk("c6_valid", 32'(out_valid),  32'd0);
    chk("c6_ready", 32'(in_ready),   32'd1);
    chk("c6_sum",   32'(sum_o),      32'd0);
    chk("c6_corr",  32'(corr_o),     32'd0);
    chk("c6_cnt",   32'(corr_cnt_o), 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("c6_idle", 32'(out_valid), 32'd0);
    send_one("c6_after", 7'd60, 7'd50, 10, 1);
    chk("c7_cnt1", 32'(corr_cnt_o), CNT_EN ? 32'd1 : 32'd0);

    // Four more corrected results: five in total, saturating a 2-bit counter.
    send_one("c7_a", 7'd99, 7'd1,  0,  1);
    send_one("c7_b", 7'd75, 7'd40, 15, 1);
    chk("c7_cnt3", 32'(corr_cnt_o), CNT_EN ? 32'd3 : 32'd0);
    send_one("c7_c", 7'd50, 7'd51, 1,  1);
    send_one("c7_d", 7'd98, 7'd97, 95, 1);
    chk("c7_sat", 32'(corr_cnt_o), CNT_EN ? 32'd3 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
